// File: rtl/race_timer.sv
// Race timer: centisecond elapsed counter with start/stop/clear, lap capture,
// timed lap display hold, best-lap tracking and saturation at MAX_CS.
module race_timer #(
    parameter int unsigned CLK_DIV = 650000,
    parameter int unsigned HOLD_CS = 200,
    parameter int unsigned MAX_CS  = 59999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] time_cs,
    output logic [15:0] elapsed_cs,
    output logic [15:0] lap_cs,
    output logic [15:0] best_cs,
    output logic        running,
    output logic        lap_valid,
    output logic        overflow
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [15:0]   HOLD_V     = 16'(HOLD_CS);
    localparam logic [15:0]   MAX_V      = 16'(MAX_CS);

    typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED, S_DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [15:0]   lap_start, lap_start_n;
    logic [15:0]   hold, hold_n;
    logic [15:0]   elapsed_n, lap_n, best_n, time_n;
    logic          running_n, lap_valid_n, overflow_n;

    logic          tick, sat, lap_acc;
    logic [15:0]   e_tick, e_lap, lap_diff;

    // Tick is decided by the registered state, so a stop in the tick cycle
    // still counts that period; the partial period survives PAUSED.
    assign tick     = (state == S_RUNNING) && (presc == PRESC_LAST) && !clear;
    assign e_tick   = elapsed_cs + 16'd1;
    assign sat      = tick && (e_tick == MAX_V);
    assign lap_acc  = (state == S_RUNNING) && lap && !stop && !clear;
    assign e_lap    = tick ? e_tick : elapsed_cs;
    assign lap_diff = e_lap - lap_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Saturation outranks a simultaneous stop so the timer ends in DONE.
    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (start) state_n = S_RUNNING;
                S_RUNNING: begin
                    if (sat)       state_n = S_DONE;
                    else if (stop) state_n = S_PAUSED;
                end
                S_PAUSED:  if (start) state_n = S_RUNNING;
                S_DONE:    state_n = S_DONE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        presc_n     = presc;
        elapsed_n   = elapsed_cs;
        lap_start_n = lap_start;
        lap_n       = lap_cs;
        best_n      = best_cs;
        hold_n      = hold;
        overflow_n  = overflow;
        lap_valid_n = lap_acc;
        if (clear) begin
            presc_n     = '0;
            elapsed_n   = '0;
            lap_start_n = '0;
            lap_n       = '0;
            best_n      = '1;
            hold_n      = '0;
            overflow_n  = 1'b0;
        end else begin
            if (state == S_IDLE && start) presc_n = '0;
            else if (state == S_RUNNING)  presc_n = tick ? '0 : presc + PW'(1);
            if (tick) elapsed_n = e_tick;
            if (sat)  overflow_n = 1'b1;
            if (lap_acc) begin
                lap_start_n = e_lap;
                lap_n       = lap_diff;
                if (lap_diff < best_cs) best_n = lap_diff;
                hold_n      = HOLD_V;
            end else if (tick && hold != '0) begin
                hold_n = hold - 16'd1;
            end
        end
        time_n    = (hold_n != '0) ? lap_n : elapsed_n;
        running_n = (state_n == S_RUNNING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            elapsed_cs <= '0;
            lap_start  <= '0;
            lap_cs     <= '0;
            best_cs    <= '1;
            hold       <= '0;
            time_cs    <= '0;
            running    <= 1'b0;
            lap_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            presc      <= presc_n;
            elapsed_cs <= elapsed_n;
            lap_start  <= lap_start_n;
            lap_cs     <= lap_n;
            best_cs    <= best_n;
            hold       <= hold_n;
            time_cs    <= time_n;
            running    <= running_n;
            lap_valid  <= lap_valid_n;
            overflow   <= overflow_n;
        end
    end

endmodule

// File: tb/tb_race_timer.sv
// Directed bench for race_timer with CLK_DIV=4, HOLD_CS=3, MAX_CS=20.
module tb_race_timer;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, clear, lap;
    logic [15:0] time_cs, elapsed_cs, lap_cs, best_cs;
    logic        running, lap_valid, overflow;
    int unsigned total = 0;
    int unsigned bad   = 0;

    race_timer #(.CLK_DIV(4), .HOLD_CS(3), .MAX_CS(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .time_cs(time_cs), .elapsed_cs(elapsed_cs), .lap_cs(lap_cs), .best_cs(best_cs),
        .running(running), .lap_valid(lap_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle control pulse, sampled at the next rising edge.
    task automatic pulse(input logic s, input logic p, input logic c, input logic l);
        start = s; stop = p; clear = c; lap = l;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        wait_clk(2);
        chk("rst_elapsed", elapsed_cs, 16'd0);
        chk("rst_time", time_cs, 16'd0);
        chk("rst_lap", lap_cs, 16'd0);
        chk("rst_best", best_cs, 16'hFFFF);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_lap_valid", {15'd0, lap_valid}, 16'd0);
        chk("rst_overflow", {15'd0, overflow}, 16'd0);
        rst_n = 1'b1;
        wait_clk(1);

        // 1: basic run, first increment 4 cycles after start
        pulse(1, 0, 0, 0);
        wait_clk(3);
        chk("t1_before_first", elapsed_cs, 16'd0);
        wait_clk(1);
        chk("t1_first_inc", elapsed_cs, 16'd1);
        wait_clk(36);
        chk("t1_elapsed", elapsed_cs, 16'd10);
        chk("t1_running", {15'd0, running}, 16'd1);
        chk("t1_time", time_cs, 16'd10);

        // 2: pause keeps the partial prescale period
        pulse(0, 0, 1, 0);
        chk("t2_cleared", elapsed_cs, 16'd0);
        pulse(1, 0, 0, 0);
        wait_clk(9);
        pulse(0, 1, 0, 0);
        chk("t2_stop_elapsed", elapsed_cs, 16'd2);
        chk("t2_stop_running", {15'd0, running}, 16'd0);
        wait_clk(50);
        chk("t2_paused_hold", elapsed_cs, 16'd2);
        pulse(1, 0, 0, 0);
        wait_clk(5);
        chk("t2_resume5", elapsed_cs, 16'd3);
        wait_clk(1);
        chk("t2_resume6", elapsed_cs, 16'd4);
        chk("t2_resume_running", {15'd0, running}, 16'd1);

        // 3: laps, best lap, display hold
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        wait_clk(20);
        chk("t3_at5", elapsed_cs, 16'd5);
        pulse(0, 0, 0, 1);
        chk("t3_lap1", lap_cs, 16'd5);
        chk("t3_best1", best_cs, 16'd5);
        chk("t3_lv1", {15'd0, lap_valid}, 16'd1);
        chk("t3_time_hold", time_cs, 16'd5);
        wait_clk(1);
        chk("t3_lv1_end", {15'd0, lap_valid}, 16'd0);
        wait_clk(9);
        chk("t3_time_last_hold", time_cs, 16'd5);
        chk("t3_elapsed7", elapsed_cs, 16'd7);
        wait_clk(1);
        chk("t3_time_release", time_cs, 16'd8);
        wait_clk(16);
        chk("t3_at12", elapsed_cs, 16'd12);
        pulse(0, 0, 0, 1);
        chk("t3_lap2", lap_cs, 16'd7);
        chk("t3_best2", best_cs, 16'd5);
        chk("t3_lv2", {15'd0, lap_valid}, 16'd1);
        chk("t3_time_lap2", time_cs, 16'd7);
        wait_clk(1);
        chk("t3_lv2_end", {15'd0, lap_valid}, 16'd0);

        // 4: saturation, DONE ignores start, clear restores
        wait_clk(40);
        chk("t4_sat_elapsed", elapsed_cs, 16'd20);
        chk("t4_overflow", {15'd0, overflow}, 16'd1);
        chk("t4_running", {15'd0, running}, 16'd0);
        chk("t4_time", time_cs, 16'd20);
        pulse(1, 0, 0, 0);
        wait_clk(8);
        chk("t4_done_elapsed", elapsed_cs, 16'd20);
        chk("t4_done_running", {15'd0, running}, 16'd0);
        pulse(0, 0, 1, 0);
        chk("t4_clr_elapsed", elapsed_cs, 16'd0);
        chk("t4_clr_lap", lap_cs, 16'd0);
        chk("t4_clr_best", best_cs, 16'hFFFF);
        chk("t4_clr_overflow", {15'd0, overflow}, 16'd0);
        chk("t4_clr_time", time_cs, 16'd0);

        // 5: priority clear>start, stop>lap
        pulse(1, 0, 1, 0);
        chk("t5_clrstart_running", {15'd0, running}, 16'd0);
        wait_clk(8);
        chk("t5_idle_elapsed", elapsed_cs, 16'd0);
        pulse(1, 0, 0, 0);
        wait_clk(5);
        chk("t5_elapsed1", elapsed_cs, 16'd1);
        pulse(0, 1, 0, 1);
        chk("t5_stoplap_running", {15'd0, running}, 16'd0);
        chk("t5_stoplap_lap", lap_cs, 16'd0);
        chk("t5_stoplap_lv", {15'd0, lap_valid}, 16'd0);
        chk("t5_stoplap_best", best_cs, 16'hFFFF);

        // 6: asynchronous reset between edges
        pulse(1, 0, 0, 0);
        wait_clk(10);
        chk("t6_elapsed4", elapsed_cs, 16'd4);
        pulse(0, 0, 0, 1);
        chk("t6_lap4", lap_cs, 16'd4);
        wait_clk(3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_elapsed", elapsed_cs, 16'd0);
        chk("t6_async_lap", lap_cs, 16'd0);
        chk("t6_async_best", best_cs, 16'hFFFF);
        chk("t6_async_time", time_cs, 16'd0);
        chk("t6_async_running", {15'd0, running}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        wait_clk(6);
        chk("t6_post_idle", elapsed_cs, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
